// File: rtl/uart_tx_pkg.sv
// Shared definitions for the RS232 transmit path: clock rate, parity modes, FSM states.
// Also holds the elaboration-time helpers for bit timing and parity.
package uart_tx_pkg;

    localparam int unsigned MCLK_HZ  = 25_175_000;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic logic parity_bit(input logic [7:0] d, input int unsigned mode);
        return (mode == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 and emits a one-cycle tick on the last count.
// Held at zero while clr is high, so the first tick lands DIV clocks after clr drops.
module baud_gen #(
    parameter int unsigned DIV = 8
) (
    input  logic MCLK,
    input  logic RST_N,
    input  logic clr,
    output logic tick
);

    localparam int unsigned     CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = !clr && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// RS232 transmitter: valid/ready byte input, 8-bit LSB-first frames, optional parity, 1 or 2 stop bits.
// States: IDLE wait for byte | START start bit | DATA 8 data bits | PAR parity bit | STOP stop bit(s)
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ    = MCLK_HZ,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned PARITY    = PAR_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       MCLK,
    input  logic       RST_N,
    input  logic [7:0] DATA,
    input  logic       VALID,
    output logic       READY,
    input  logic       CTS_N,
    output logic       TX,
    output logic       BUSY
);

    localparam int unsigned DIV       = baud_div(CLK_HZ, BAUD);
    localparam logic        STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    generate
        if (PARITY > PAR_EVEN) begin : g_bad_parity
            $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
        end
        if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx: CLK_HZ/BAUD gives fewer than 2 clocks per bit");
        end
    endgenerate

    state_t     r_state;
    logic [7:0] r_shift;
    logic       r_par;
    logic [2:0] r_bit_idx;
    logic       r_stop_idx;
    logic       r_tx;
    logic       r_cts_meta;
    logic       r_cts_s;

    state_t     w_state_nxt;
    logic [7:0] w_shift_nxt;
    logic       w_par_nxt;
    logic [2:0] w_bit_idx_nxt;
    logic       w_stop_idx_nxt;
    logic       w_tx_nxt;
    logic       w_accept;
    logic       w_tick;
    logic       w_baud_clr;

    // Timer is parked in IDLE, so the accept edge starts the start bit from count 0.
    assign w_baud_clr = (r_state == S_IDLE);

    baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .MCLK  (MCLK),
        .RST_N (RST_N),
        .clr   (w_baud_clr),
        .tick  (w_tick)
    );

    assign READY    = (r_state == S_IDLE) && !r_cts_s;
    assign w_accept = VALID && READY;
    assign BUSY     = (r_state != S_IDLE);
    assign TX       = r_tx;

    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            r_cts_meta <= 1'b1;
            r_cts_s    <= 1'b1;
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_cts_meta <= CTS_N;
            r_cts_s    <= r_cts_meta;
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_par_nxt      = r_par;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_tx_nxt       = 1'b1;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = S_START;
                    w_shift_nxt    = DATA;
                    w_par_nxt      = parity_bit(DATA, PARITY);
                    w_bit_idx_nxt  = '0;
                    w_stop_idx_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = (PARITY == PAR_NONE) ? S_STOP : S_PAR;
                    end else begin
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_stop_idx == STOP_LAST) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // TX is a function of where the FSM lands, so the line changes on the same edge as the state.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            S_PAR:   w_tx_nxt = w_par_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity/1 stop, even/1 stop, odd/2 stops) with a
// per-instance line monitor that checks every frame sample-by-sample against queued bytes.
module tb_uart_tx;

    localparam int DIV = 8;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       cts_n;
    logic [7:0] data;
    logic [2:0] valid;
    logic [2:0] w_ready;
    logic [2:0] w_tx;
    logic [2:0] w_busy;

    exp_t exp_q[$];
    int   n_vec;
    int   n_miss;
    int   frames_done[3];
    int   last_gap[3];

    uart_tx #(.CLK_HZ(80), .BAUD(10), .PARITY(0), .STOP_BITS(1)) u_dut_none (
        .MCLK(clk), .RST_N(rst_n), .DATA(data), .VALID(valid[0]), .READY(w_ready[0]),
        .CTS_N(cts_n), .TX(w_tx[0]), .BUSY(w_busy[0]));

    uart_tx #(.CLK_HZ(80), .BAUD(10), .PARITY(2), .STOP_BITS(1)) u_dut_even (
        .MCLK(clk), .RST_N(rst_n), .DATA(data), .VALID(valid[1]), .READY(w_ready[1]),
        .CTS_N(cts_n), .TX(w_tx[1]), .BUSY(w_busy[1]));

    uart_tx #(.CLK_HZ(80), .BAUD(10), .PARITY(1), .STOP_BITS(2)) u_dut_odd2 (
        .MCLK(clk), .RST_N(rst_n), .DATA(data), .VALID(valid[2]), .READY(w_ready[2]),
        .CTS_N(cts_n), .TX(w_tx[2]), .BUSY(w_busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int frame_len(input int par, input int nstop);
        return (1 + 8 + ((par != 0) ? 1 : 0) + nstop) * DIV;
    endfunction

    // Expected TX sample per clock, bit i = i-th clock after accept.
    function automatic logic [127:0] frame_model(input logic [7:0] d, input int par, input int nstop);
        logic [127:0] v;
        logic [127:0] fill;
        logic [7:0]   sh;
        int           pos;
        logic         pbit;
        v    = '0;
        fill = (128'(1) << DIV) - 128'(1);
        sh   = d;
        pos  = DIV;
        for (int b = 0; b < 8; b++) begin
            if (sh[0]) v = v | (fill << pos);
            sh  = sh >> 1;
            pos = pos + DIV;
        end
        if (par != 0) begin
            pbit = (par == 2) ? ^d : ~^d;
            if (pbit) v = v | (fill << pos);
            pos = pos + DIV;
        end
        for (int s = 0; s < nstop; s++) begin
            v   = v | (fill << pos);
            pos = pos + DIV;
        end
        return v;
    endfunction

    task automatic monitor(input logic [1:0] idx, input int par, input int nstop);
        int           len;
        int           idle;
        logic [127:0] obs;
        logic [127:0] obs_b;
        logic [127:0] ones;
        logic         aborted;
        exp_t         e;
        len  = frame_len(par, nstop);
        ones = (128'(1) << len) - 128'(1);
        idle = 0;
        forever begin
            @(negedge clk);
            if (rst_n && (w_tx[idx] == 1'b0)) begin
                last_gap[idx] = idle;
                obs     = '0;
                obs_b   = '0;
                aborted = 1'b0;
                for (int i = 0; i < len; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    obs   = obs   | (128'(w_tx[idx])   << i);
                    obs_b = obs_b | (128'(w_busy[idx]) << i);
                end
                chk($sformatf("exp_pending%0d", idx), 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                end else begin
                    e.idx  = 2'd3;
                    e.data = 8'h00;
                end
                chk($sformatf("frame_owner%0d", idx), 128'(e.idx), 128'(idx));
                if (!aborted) begin
                    chk($sformatf("frame%0d_%02h", idx, e.data), obs, frame_model(e.data, par, nstop));
                    chk($sformatf("busy%0d_%02h", idx, e.data), obs_b, ones);
                    @(negedge clk);
                    chk($sformatf("post%0d_txbusy", idx), 128'({w_tx[idx], w_busy[idx]}), 128'(2'b10));
                    idle = w_tx[idx] ? 1 : 0;
                    frames_done[idx]++;
                end else begin
                    idle = 0;
                end
            end else begin
                idle++;
            end
        end
    endtask

    initial monitor(2'd0, 0, 1);
    initial monitor(2'd1, 2, 1);
    initial monitor(2'd2, 1, 2);

    task automatic push_exp(input logic [1:0] idx, input logic [7:0] d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Waits for READY at a negedge; returns #1 after the accepting edge.
    task automatic wait_accept(input logic [1:0] idx);
        int n;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (w_ready[idx]) break;
            n++;
        end
        chk("accept_timeout", 128'(n < 400), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] idx, input logic [7:0] d);
        @(posedge clk);
        #1;
        data       = d;
        valid[idx] = 1'b1;
        push_exp(idx, d);
        wait_accept(idx);
        valid[idx] = 1'b0;
    endtask

    task automatic wait_frames(input logic [1:0] idx, input int n);
        int t;
        t = 0;
        while ((frames_done[idx] < n) && (t < 400)) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("frames_done%0d", idx), 128'(frames_done[idx]), 128'(n));
    endtask

    // CTS_N just dropped after an edge: READY stays low one more edge, rises on the second.
    task automatic check_cts_release(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_rdy_e1"}, 128'(w_ready), 128'(3'b000));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_rdy_e2"}, 128'(w_ready), 128'(3'b111));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        n_vec  = 0;
        n_miss = 0;
        for (int i = 0; i < 3; i++) begin
            frames_done[i] = 0;
            last_gap[i]    = -1;
        end
        rst_n = 1'b0;
        cts_n = 1'b0;
        data  = 8'h00;
        valid = 3'b000;

        // Reset values, then synchroniser flush after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 128'({w_tx, w_busy, w_ready}), 128'({3'b111, 3'b000, 3'b000}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_release", 128'(w_ready), 128'(3'b000));
        check_cts_release("rst");

        // Basic frames on each configuration.
        send(2'd0, 8'h55);
        wait_frames(2'd0, 1);
        send(2'd1, 8'h07);
        wait_frames(2'd1, 1);
        send(2'd2, 8'h07);
        wait_frames(2'd2, 1);

        // CTS held off with a byte pending: nothing may go out.
        @(posedge clk);
        #1;
        cts_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        data     = 8'h41;
        valid[0] = 1'b1;
        push_exp(2'd0, 8'h41);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if ((w_ready != 3'b000) || (w_tx[0] != 1'b1) || w_busy[0]) bad++;
        end
        chk("cts_block", 128'(bad), 128'(0));
        @(posedge clk);
        #1;
        cts_n = 1'b0;
        check_cts_release("cts_hold");
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        wait_frames(2'd0, 2);

        // CTS deasserted during data bit 3: frame finishes intact, then READY stays low.
        send(2'd0, 8'hA5);
        repeat (34) @(posedge clk);
        #1;
        cts_n = 1'b1;
        wait_frames(2'd0, 3);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (w_ready[0]) bad++;
        end
        chk("cts_mid_ready", 128'(bad), 128'(0));
        @(posedge clk);
        #1;
        cts_n = 1'b0;
        check_cts_release("cts_mid");

        // Back-to-back with VALID held; DATA changes right after the first accept.
        @(posedge clk);
        #1;
        data     = 8'hA5;
        valid[0] = 1'b1;
        push_exp(2'd0, 8'hA5);
        wait_accept(2'd0);
        data = 8'h3C;
        push_exp(2'd0, 8'h3C);
        wait_accept(2'd0);
        valid[0] = 1'b0;
        wait_frames(2'd0, 5);
        chk("b2b_gap", 128'(last_gap[0]), 128'(1));

        // Reset pulse during data bit 5 aborts the frame.
        send(2'd0, 8'h96);
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_state", 128'({w_tx[0], w_busy[0], w_ready}), 128'({1'b1, 1'b0, 3'b000}));
        check_cts_release("abort");
        send(2'd0, 8'h3C);
        wait_frames(2'd0, 6);

        repeat (20) @(negedge clk);
        chk("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit side of the RS232 link, driving RS232_TX and honouring RS232_CTS; the counterpart to the board's receive path on RS232_RX.
- Accepts bytes over a valid/ready handshake and serialises them as 8-bit, LSB-first asynchronous frames with optional parity and 1 or 2 stop bits.
- Sits in the top level between application logic and the RS232 pins. RS232_RTS is tied low (ready) outside this block.

Parameters:
- CLK_HZ, 25175000, MCLK frequency in Hz.
- BAUD, 9600, bit rate. DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit; DIV must be >= 2.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- MCLK  in  1  system clock; all logic on its rising edge.
- RST_N  in  1  synchronous reset, active low.
- DATA  in  8  byte to send; sampled only on accept.
- VALID  in  1  DATA is valid.
- READY  out  1  block will accept on this edge if VALID=1.
- CTS_N  in  1  clear-to-send, active low, asynchronous to MCLK; 0 means the peer may receive.
- TX  out  1  serial line; idle level 1.
- BUSY  out  1  a frame is in progress (state other than IDLE).

Behaviour:
- One clock domain; reset is synchronous and active low. Reset values: TX=1, READY=0, BUSY=0, state IDLE, baud counter 0, CTS synchroniser flops 1 (not clear).
- CTS_N passes through a 2-flop synchroniser to give cts_s. After CTS_N falls, READY can rise on the 2nd following edge.
- READY = (state==IDLE) && !cts_s. This is a registered state decode; there is no combinational path from VALID.
- Accept happens on an edge where VALID && READY:
  - Latch DATA into the shift register and compute the parity bit (odd: ~^DATA; even: ^DATA).
  - Enter START and clear the baud counter.
  - TX goes 0 on that same edge, so the start bit is visible from the cycle after accept.
- States and transitions:
  - IDLE -> START on accept.
  - START -> DATA after DIV cycles.
  - DATA -> PAR, or STOP if PARITY==0, after 8 bit-times. Bits are sent LSB first; shift on each bit boundary.
  - PAR -> STOP after DIV cycles.
  - STOP -> IDLE after STOP_BITS*DIV cycles.
- Every bit is held for exactly DIV clocks. The baud counter runs 0..DIV-1 and wraps to 0 at each bit boundary. A 3-bit counter tracks the data bit index.
- TX is registered and is 1 in IDLE and STOP.
- Frame length = (1 + 8 + (PARITY!=0) + STOP_BITS) * DIV clocks.
- Back-to-back frames: the FSM spends exactly one cycle in IDLE (READY=1) between frames. With VALID held, the inter-frame idle gap is 1 clock.
- CTS_N deasserted mid-frame: the current frame completes unchanged, then READY stays 0 while cts_s=1.
- DATA/VALID activity while not READY is ignored. The latched byte never changes mid-frame.
- RST_N low mid-frame: the frame aborts on that edge (TX=1, IDLE). READY stays 0 for at least 2 cycles after RST_N rises, until the synchroniser flushes.
- PARITY values outside 0..2 and STOP_BITS outside 1..2 are illegal; an elaboration-time check flags them.

Decomposition:
- Shared package/header up2_defs.vh holds:
  - MCLK_HZ = 25175000.
  - Parity encodings PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - FSM state encodings S_IDLE, S_START, S_DATA, S_PAR, S_STOP.
- One natural sub-module: baud_gen. Parameter DIV; inputs MCLK, RST_N, clr; output tick, a 1-cycle pulse every DIV clocks after clr. The FSM advances on tick.

Test Plan:
- Bench parameters: CLK_HZ=80, BAUD=10 (DIV=8), PARITY=0, STOP_BITS=1.
- Reset, CTS_N=0, send 0x55 -> READY high from the 3rd edge after reset; after accept TX = 0 for 8 clocks, then 1,0,1,0,1,0,1,0 at 8 clocks each, then 1 for 8 clocks; BUSY high for exactly 80 clocks.
- PARITY=2, send 0x07 -> parity bit 1; PARITY=1, send 0x07 -> parity bit 0; frame is 88 clocks. STOP_BITS=2 -> stop phase is 16 clocks.
- CTS_N=1 with VALID=1 and DATA=0x41 -> TX stays 1 and READY=0 indefinitely; drop CTS_N -> READY rises on the 2nd edge, 0x41 is sent once.
- Raise CTS_N during data bit 3 of 0xA5 -> frame completes bit-exact; afterwards READY=0 until CTS_N returns low.
- VALID held with 0xA5 then 0x3C -> two frames separated by exactly 1 idle clock; DATA changed mid-frame does not alter the first frame.
- RST_N low for 1 cycle during data bit 5 -> TX=1 from that edge, BUSY=0, READY=0 for 2 cycles after release, then the next accept sends a clean frame.
